mem_access: RTL

- MEM-stage data-memory access unit. Sits between the ex_mem pipeline register and the mem_wb register.
- Decodes load/store micro-ops and runs a req/ack transaction on the data bus. It asserts stallreq while the bus is busy.
- Formats load data with byte/halfword select and sign/zero extension. Passes the result (wd/wreg/wdata/hi/lo/hilo) downstream to mem_wb.

---
 rtl/mem_access.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with req/ack data bus, lane select and load extension; MEM_TIMEOUT_EN adds a WAIT timeout abort.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_hilo,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stallreq,
  output logic        bus_err,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_hilo
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] rdata_q, ld, rep;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [3:0] sel_c;
  logic [1:0] a;
  logic flushed_q, to_err_q, timeout;
  logic is_load, is_store, is_mem, is_byte, is_half, is_word, misal, go;
  assign a        = ex_mem_addr[1:0];
  assign is_load  = ex_memop inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  assign is_store = ex_memop inside {4'd6, 4'd7, 4'd8};
  assign is_mem   = is_load | is_store;
  assign is_byte  = ex_memop inside {4'd1, 4'd2, 4'd6};
  assign is_half  = ex_memop inside {4'd3, 4'd4, 4'd7};
  assign is_word  = ex_memop inside {4'd5, 4'd8};
  assign misal    = (is_half & a[0]) | (is_word & |a);
  assign go       = state == IDLE && is_mem && !flush && !misal;
  assign sel_c    = is_byte ? 4'b1000 >> a : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign rep      = is_byte ? {4{ex_reg2[7:0]}} : is_half ? {2{ex_reg2[15:0]}} : ex_reg2;
  // lanes are big-endian: address offset 0 is the most significant byte
  assign lb = a == 2'd0 ? rdata_q[31:24] : a == 2'd1 ? rdata_q[23:16] : a == 2'd2 ? rdata_q[15:8] : rdata_q[7:0];
  assign lh = a[1] ? rdata_q[15:0] : rdata_q[31:16];
  assign ld = ex_memop == 4'd1 ? {{24{lb[7]}}, lb} :
              ex_memop == 4'd2 ? {24'd0, lb} :
              ex_memop == 4'd3 ? {{16{lh[15]}}, lh} :
              ex_memop == 4'd4 ? {16'd0, lh} : rdata_q;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  assign timeout = state == WAIT && !dbus_ack && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 8'd0;
      to_err_q <= 1'b0;
    end else begin
      cnt      <= (state == WAIT && state_n == WAIT) ? cnt + 8'd1 : 8'd0;
      to_err_q <= timeout;
    end
  end
`else
  assign timeout  = 1'b0;
  assign to_err_q = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_sel   = 4'd0;
    dbus_wdata = 32'd0;
    stallreq   = 1'b0;
    bus_err    = 1'b0;
    mem_wd     = 5'd0;
    mem_wreg   = 1'b0;
    mem_wdata  = 32'd0;
    mem_hi     = 32'd0;
    mem_lo     = 32'd0;
    mem_hilo   = 1'b0;
    if (!rst) begin
      mem_wd    = ex_wd;
      mem_wdata = ex_wdata;
      mem_hi    = ex_hi;
      mem_lo    = ex_lo;
      case (state)
        IDLE: begin
          mem_wreg = ex_wreg & !flush & !is_mem;
          mem_hilo = ex_hilo & !flush & !is_mem;
          bus_err  = is_mem & !flush & misal;
          if (go) state_n = dbus_ack ? DONE : WAIT;
        end
        WAIT: begin
          if (dbus_ack) state_n = (flushed_q | flush) ? IDLE : DONE;
          else if (timeout) state_n = DONE;
        end
        DONE: begin
          mem_wdata = is_load ? ld : ex_wdata;
          mem_wreg  = ex_wreg & is_load & !flush & !to_err_q;
          mem_hilo  = ex_hilo & !flush;
          bus_err   = to_err_q;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
      dbus_req   = go | (state == WAIT);
      stallreq   = dbus_req;
      dbus_we    = dbus_req & is_store;
      dbus_addr  = dbus_req ? {ex_mem_addr[31:2], 2'b00} : 32'd0;
      dbus_sel   = dbus_req ? sel_c : 4'd0;
      dbus_wdata = (dbus_req & is_store) ? rep : 32'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdata_q   <= 32'd0;
      flushed_q <= 1'b0;
    end else begin
      state     <= state_n;
      if (dbus_req && dbus_ack) rdata_q <= dbus_rdata;
      flushed_q <= state == WAIT && state_n == WAIT && (flushed_q | flush);
    end
  end
endmodule
